// File: rtl/perforator.sv
// Transmit-side puncturer: drops encoder bits per code-rate mask and repacks
// the survivors into 2-bit symbols, tagging the first kept bit of each period.
module perforator #(
   parameter logic [2:0] P34_X = 3'b101,
   parameter logic [2:0] P34_Y = 3'b110,
   parameter logic [6:0] P78_X = 7'b1000101,
   parameter logic [6:0] P78_Y = 7'b1111010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_code_rate,
   input  logic       i_vld,
   output logic       o_rdy,
   input  logic [1:0] i_data,
   output logic       o_vld,
   input  logic       i_rdy,
   output logic [1:0] o_data,
   output logic       o_sop
);

   localparam logic [1:0] R12 = 2'd0;
   localparam logic [1:0] R34 = 2'd1;
   localparam logic [1:0] R78 = 2'd2;

   function automatic logic [1:0] norm_rate(input logic [1:0] rate);
      return (rate == 2'd3) ? R12 : rate;
   endfunction

   // {keep X, keep Y} for one step; mask MSB corresponds to step 0
   function automatic logic [1:0] keep_bits(input logic [1:0] rate, input logic [2:0] step);
      logic [1:0] k;
      k = 2'b11;
      case (rate)
         R34: k = {P34_X[2'(3'd2 - step)], P34_Y[2'(3'd2 - step)]};
         R78: k = {P78_X[3'd6 - step], P78_Y[3'd6 - step]};
         default: k = 2'b11;
      endcase
      return k;
   endfunction

   function automatic logic period_last(input logic [1:0] rate, input logic [2:0] step);
      logic last;
      case (rate)
         R34:     last = (step == 3'd2);
         R78:     last = (step == 3'd6);
         default: last = 1'b1;
      endcase
      return last;
   endfunction

   // Accumulator slot 0 is the oldest bit
   logic [2:0] acc_bit_p0;
   logic [2:0] acc_tag_p0;
   logic [1:0] cnt_p0;
   logic [2:0] step_p0;
   logic [1:0] rate_p0;

   logic [1:0] rate_eff;
   logic [1:0] keep;
   logic       accept;
   logic       fire;
   logic [2:0] nxt_bit;
   logic [2:0] nxt_tag;
   logic [1:0] nxt_cnt;

   assign o_vld  = (cnt_p0 >= 2'd2);
   assign o_rdy  = !reset & ((cnt_p0 <= 2'd1) | i_rdy);
   assign o_data = {acc_bit_p0[0], acc_bit_p0[1]};
   assign o_sop  = acc_tag_p0[0];

   // A new rate is only honoured when a period begins
   always_comb begin
      rate_eff = (step_p0 == 3'd0) ? norm_rate(i_code_rate) : rate_p0;
      keep     = keep_bits(rate_eff, step_p0);
      accept   = i_vld & o_rdy;
      fire     = o_vld & i_rdy;
      nxt_bit  = acc_bit_p0;
      nxt_tag  = acc_tag_p0;
      nxt_cnt  = cnt_p0;
      if (fire) begin
         nxt_bit = {2'b00, acc_bit_p0[2]};
         nxt_tag = {2'b00, acc_tag_p0[2]};
         nxt_cnt = cnt_p0 - 2'd2;
      end
      if (accept) begin
         if (keep[1]) begin
            nxt_bit[nxt_cnt] = i_data[1];
            nxt_tag[nxt_cnt] = (step_p0 == 3'd0);
            nxt_cnt          = nxt_cnt + 2'd1;
         end
         if (keep[0]) begin
            nxt_bit[nxt_cnt] = i_data[0];
            nxt_tag[nxt_cnt] = (step_p0 == 3'd0) & !keep[1];
            nxt_cnt          = nxt_cnt + 2'd1;
         end
      end
   end

   // Stage p0: accumulator, step counter and latched rate
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_bit_p0 <= 3'b000;
         acc_tag_p0 <= 3'b000;
         cnt_p0     <= 2'd0;
         step_p0    <= 3'd0;
         rate_p0    <= R12;
      end else begin
         acc_bit_p0 <= nxt_bit;
         acc_tag_p0 <= nxt_tag;
         cnt_p0     <= nxt_cnt;
         if (accept) begin
            step_p0 <= period_last(rate_eff, step_p0) ? 3'd0 : step_p0 + 3'd1;
            rate_p0 <= rate_eff;
         end
      end
   end

endmodule

// File: tb/tb_perforator.sv
// Scoreboard bench for perforator: queue-based reference model fed on every
// accept, monitor pops and compares on every fire.
module tb_perforator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] i_code_rate = 2'd0;
   logic       i_vld = 1'b0;
   logic       o_rdy;
   logic [1:0] i_data = 2'b00;
   logic       o_vld;
   logic       i_rdy = 1'b1;
   logic [1:0] o_data;
   logic       o_sop;

   int checks = 0;
   int failures = 0;
   int rdy_mode = 0;

   logic [2:0] exp_q[$];
   logic [2:0] got_q[$];
   logic [1:0] pend_q[$];
   int mstep = 0;
   int mrate = 0;

   int k34x[3] = '{1, 0, 1};
   int k34y[3] = '{1, 1, 0};
   int k78x[7] = '{1, 0, 0, 0, 1, 0, 1};
   int k78y[7] = '{1, 1, 1, 1, 0, 1, 0};

   perforator dut (
      .clk(clk), .reset(reset), .i_code_rate(i_code_rate), .i_vld(i_vld),
      .o_rdy(o_rdy), .i_data(i_data), .o_vld(o_vld), .i_rdy(i_rdy),
      .o_data(o_data), .o_sop(o_sop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int plen(input int r);
      if (r == 1) return 3;
      if (r == 2) return 7;
      return 1;
   endfunction

   task automatic model_accept(input bit x, input bit y, input int rate_in);
      int kx;
      int ky;
      logic [1:0] a;
      logic [1:0] b;
      if (mstep == 0) mrate = (rate_in == 3) ? 0 : rate_in;
      case (mrate)
         1: begin kx = k34x[mstep]; ky = k34y[mstep]; end
         2: begin kx = k78x[mstep]; ky = k78y[mstep]; end
         default: begin kx = 1; ky = 1; end
      endcase
      if (kx != 0) pend_q.push_back({x, 1'(mstep == 0)});
      if (ky != 0) pend_q.push_back({y, 1'((mstep == 0) && (kx == 0))});
      mstep = (mstep + 1) % plen(mrate);
      while (pend_q.size() >= 2) begin
         a = pend_q.pop_front();
         b = pend_q.pop_front();
         exp_q.push_back({a[1], b[1], a[0]});
      end
   endtask

   // Monitor: everything is stable at the falling edge for the next rising edge
   logic       stall_prev = 1'b0;
   logic [2:0] held = 3'b000;
   logic [2:0] e;
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         pend_q.delete();
         mstep = 0;
         mrate = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_hold_vld", int'(o_vld), 1);
            chk("stall_hold_data_sop", int'({o_data, o_sop}), int'(held));
         end
         if (o_vld && i_rdy) begin
            got_q.push_back({o_data, o_sop});
            chk("symbol_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("symbol_data_sop", int'({o_data, o_sop}), int'(e));
            end
         end
         if (i_vld && o_rdy) model_accept(i_data[1], i_data[0], int'(i_code_rate));
         stall_prev = o_vld && !i_rdy;
         held = {o_data, o_sop};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         i_rdy = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input bit x, input bit y, input int r);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      i_vld = 1'b1;
      i_data = {x, y};
      i_code_rate = 2'(r);
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = o_rdy;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_accepted", int'(acc), 1);
      i_vld = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      i_vld = 1'b0;
      rdy_mode = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic cmp_got(input string name, input logic [2:0] ref_q[$]);
      chk({name, "_count"}, got_q.size(), ref_q.size());
      for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
         chk(name, int'(got_q[i]), int'(ref_q[i]));
   endtask

   logic [2:0] ref_q[$];

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_o_vld", int'(o_vld), 0);
      chk("reset_o_rdy", int'(o_rdy), 0);
      chk("reset_o_data", int'(o_data), 0);
      chk("reset_o_sop", int'(o_sop), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Rate 1/2 with latency probe on the first pair
      got_q.delete();
      send(1, 0, 0);
      @(negedge clk);
      chk("latency_o_vld", int'(o_vld), 1);
      chk("latency_o_data", int'(o_data), 2);
      @(posedge clk);
      #1;
      send(0, 1, 0);
      send(1, 1, 0);
      drain();
      ref_q = '{3'b101, 3'b011, 3'b111};
      cmp_got("rate12", ref_q);

      // Rate 3/4 single period
      got_q.delete();
      send(1, 0, 1);
      send(0, 1, 1);
      send(1, 1, 1);
      drain();
      ref_q = '{3'b101, 3'b110};
      cmp_got("rate34", ref_q);

      // Rate 7/8 single period
      got_q.delete();
      send(1, 1, 2);
      send(0, 0, 2);
      send(1, 0, 2);
      send(0, 1, 2);
      send(1, 1, 2);
      send(0, 1, 2);
      send(1, 0, 2);
      drain();
      ref_q = '{3'b111, 3'b000, 3'b110, 3'b110};
      cmp_got("rate78", ref_q);

      // Rate request changes mid-period, then rate code 3
      got_q.delete();
      send(1, 1, 1);
      send(0, 1, 0);
      send(1, 0, 0);
      send(0, 1, 0);
      send(1, 0, 3);
      drain();
      ref_q = '{3'b111, 3'b110, 3'b011, 3'b101};
      cmp_got("rate_change", ref_q);

      // Reset after two of three accepts at rate 3/4
      got_q.delete();
      send(1, 1, 1);
      send(0, 1, 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_o_vld", int'(o_vld), 0);
      chk("midreset_o_rdy", int'(o_rdy), 0);
      ref_q = '{3'b111};
      cmp_got("pre_reset", ref_q);
      @(posedge clk);
      #1;
      reset = 1'b0;
      got_q.delete();
      send(0, 1, 1);
      send(1, 1, 1);
      send(1, 0, 1);
      drain();
      ref_q = '{3'b011, 3'b110};
      cmp_got("post_reset", ref_q);

      // Rate 7/8 random data with random downstream stalls
      got_q.delete();
      rdy_mode = 1;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
         send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
      end
      drain();
      chk("rand78_symbols", got_q.size(), 400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
